// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, wrap or saturate at the bounds,
// registered ovf/unf/load_err event pulses and combinational terminal flags.
module updown_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam bit               FULL_RANGE = (MAX_VAL == {WIDTH{1'b1}});

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             lerr_q, lerr_d;
    logic             load_over;

    // A full-range modulus can never see an out-of-range load value.
    generate
        if (FULL_RANGE) begin : g_full
            assign load_over = 1'b0;
        end else begin : g_part
            assign load_over = (data_in > MAX_VAL);
        end
    endgenerate

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        lerr_d = 1'b0;
        if (ld) begin
            if (load_over) begin
                cnt_d  = MAX_VAL;
                lerr_d = 1'b1;
            end else begin
                cnt_d  = data_in;
            end
        end else if (inc && !dec) begin
            if (cnt_q == MAX_VAL) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : MAX_VAL;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RESET_VAL;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            lerr_q <= lerr_d;
        end
    end

    assign q        = cnt_q;
    assign at_max   = (cnt_q == MAX_VAL);
    assign at_min   = (cnt_q == '0);
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign load_err = lerr_q;

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the team's 8-bit load/increment counter. Adds configurable width and modulus, a decrement path, and a selectable wrap or saturate mode. Also adds registered overflow, underflow and load-error pulses plus terminal-count flags. Intended as the general-purpose counting primitive for the workshop benches and datapaths, with one clock domain and a synchronous reset.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: highest count value (modulus is MAX_VAL+1); must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.
- RESET_VAL, 0: value of q after reset; must be <= MAX_VAL.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  WIDTH  load value.
- ld  in  1  load enable.
- inc  in  1  count up by 1.
- dec  in  1  count down by 1.
- q  out  WIDTH  registered count.
- at_max  out  1  combinational; high when q == MAX_VAL.
- at_min  out  1  combinational; high when q == 0.
- ovf  out  1  registered one-cycle pulse on an up-count from MAX_VAL.
- unf  out  1  registered one-cycle pulse on a down-count from 0.
- load_err  out  1  registered one-cycle pulse on a load value greater than MAX_VAL.

## Operation
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; rst asserted between edges has no effect until the next rising edge.
- Priority per edge is rst > ld > (inc XOR dec) > hold.
- rst: q <= RESET_VAL; ovf, unf and load_err <= 0.
- ld: q <= data_in if data_in <= MAX_VAL.
  - Otherwise q <= MAX_VAL and load_err <= 1.
  - inc and dec are ignored, and ovf/unf stay 0.
- inc with dec low:
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL: ovf <= 1, and q <= 0 (SATURATE=0) or q holds (SATURATE=1).
- dec with inc low:
  - q > 0: q <= q-1.
  - q == 0: unf <= 1, and q <= MAX_VAL (SATURATE=0) or q holds (SATURATE=1).
- inc and dec both high: q holds; no flags.
- Pulse outputs: ovf, unf and load_err are 0 on every edge where their condition does not hold, so each is a single-cycle pulse per event.
- Repeated events: back-to-back events produce back-to-back pulses. In saturate mode, sustained inc at MAX_VAL gives ovf high every cycle.
- Arithmetic: internal next-state computed at WIDTH bits. Comparison against MAX_VAL is unsigned, and no intermediate value exceeds WIDTH bits.

## Timing
- Latency: q, ovf, unf and load_err change only after a rising clk edge, one cycle after the controlling inputs are sampled.
- Sampling: inputs are sampled at the rising edge and must be stable by then. Benches drive on negedge or sample #1ns after posedge.
- Terminal flags: at_max and at_min follow q in the same cycle, with no extra register stage.
- Reset mid-count: rst asserted between edges does not change q until the next rising edge. The first edge with rst high forces RESET_VAL regardless of ld/inc/dec.
- Reset release: the first edge after rst deasserts processes ld/inc/dec normally.

## Test plan
- WIDTH=8, MAX_VAL=255, SATURATE=0: reset, then inc held 300 cycles.
  - q tracks a model modulo 256.
  - q == 0 and ovf == 1 exactly at cycles 256 after inc start; ovf is 0 elsewhere.
- WIDTH=8, MAX_VAL=199, SATURATE=0: ld 0xC7, then dec from 0.
  - inc at 199 gives q = 0 with ovf pulse.
  - dec at 0 gives q = 199 with unf pulse.
  - at_max is high only while q == 199.
- Same params with SATURATE=1: ld 199, inc held 3 cycles, then ld 0, dec held 3 cycles.
  - q stays 199 with ovf high 3 cycles.
  - q stays 0 with unf high 3 cycles.
- Priority checks:
  - ld=1, inc=1, data_in=0x10 gives q = 0x10 with no ovf.
  - ld with data_in=250 (MAX_VAL=199) gives q = 199 and a load_err pulse.
  - inc=dec=1 at q=5 leaves q at 5.
- Synchronous reset: count to 0x20, assert rst on a negedge.
  - #1ns later q is still 0x20.
  - After the next posedge, q = RESET_VAL and all pulses are 0.
  - The first edge after rst release with inc=1 gives q = RESET_VAL+1.
